// File: rtl/gf16_inv_rnd_sched.sv
// Controller and fresh-randomness scheduler for the masked GF(2^4) inverter
// stage of the 2-share TI S-box pipeline. Buffers PRNG words, hands exactly
// one unused word to the inverter per issued operation, and drives per-stage
// register enables plus tag tracking through a fixed-depth pipeline with a
// global stall under output backpressure. No share data passes through here.
module gf16_inv_rnd_sched #(
    parameter int STAGES     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       rnd_in,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              in_ready,
    output logic [11:0]       r_out,
    output logic [STAGES-1:0] stage_en,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              out_ready,
    input  logic              flush,
    output logic [15:0]       starve_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Randomness buffer state
    logic [11:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fifo_count_r;

    // Pipeline bookkeeping state
    logic [STAGES-1:0] v_r;
    logic [TAG_W-1:0]  tag_r [STAGES];
    logic [15:0]       starve_cnt_r;

    // Combinational control
    logic              run_s;
    logic              fifo_nonempty_s;
    logic              fifo_full_s;
    logic              adv_s;
    logic              in_ready_s;
    logic              issue_s;
    logic              rnd_ready_s;
    logic              push_s;
    logic              starve_s;
    logic [STAGES-1:0] stage_en_s;
    logic [11:0]       r_out_s;

    // Outputs are gated by rst_n so that the reset cycle itself presents a
    // quiet interface even while the registers still hold pre-reset state.
    assign run_s           = rst_n;
    assign fifo_nonempty_s = (fifo_count_r != {CNT_W{1'b0}});
    assign fifo_full_s     = (fifo_count_r == CNT_W'(FIFO_DEPTH));

    // A full last stage that nobody takes stalls the whole pipeline.
    assign adv_s       = !v_r[STAGES-1] || out_ready;
    assign in_ready_s  = run_s && adv_s && fifo_nonempty_s && !flush;
    assign issue_s     = in_valid && in_ready_s;
    assign rnd_ready_s = run_s && !fifo_full_s;
    assign push_s      = rnd_valid && rnd_ready_s;
    assign starve_s    = run_s && in_valid && adv_s && !fifo_nonempty_s && !flush;

    // Per-stage load enables: stage 0 loads on issue, later stages follow their valid predecessor.
    always_comb begin
        stage_en_s    = {STAGES{1'b0}};
        stage_en_s[0] = issue_s;
        for (int i = 1; i < STAGES; i++) begin
            stage_en_s[i] = run_s && adv_s && v_r[i-1] && !flush;
        end
    end

    // Present the FIFO head to the inverter; zero when no fresh word is buffered.
    always_comb begin
        r_out_s = 12'h000;
        if (run_s && fifo_nonempty_s) begin
            r_out_s = fifo_mem_r[rd_ptr_r];
        end else begin
            r_out_s = 12'h000;
        end
    end

    // Randomness FIFO storage and pointers; the head is consumed only by an issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 12'h000;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= rnd_in;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, issue_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Valid/tag shift register; flush wins over advance, stall holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                tag_r[i] <= {TAG_W{1'b0}};
            end
        end else if (flush) begin
            v_r <= {STAGES{1'b0}};
        end else if (adv_s) begin
            v_r[0]   <= issue_s;
            tag_r[0] <= issue_s ? in_tag : {TAG_W{1'b0}};
            for (int i = 1; i < STAGES; i++) begin
                v_r[i]   <= v_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end else begin
            v_r <= v_r;
        end
    end

    // Saturating count of cycles where a request could advance but had no randomness.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= 16'h0000;
        end else if (starve_s && (starve_cnt_r != 16'hFFFF)) begin
            starve_cnt_r <= starve_cnt_r + 16'h0001;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign rnd_ready  = rnd_ready_s;
    assign in_ready   = in_ready_s;
    assign r_out      = r_out_s;
    assign stage_en   = stage_en_s;
    assign out_valid  = run_s && v_r[STAGES-1];
    assign out_tag    = tag_r[STAGES-1];
    assign starve_cnt = starve_cnt_r;

endmodule

// File: tb/tb_gf16_inv_rnd_sched.sv
// Self-checking bench for gf16_inv_rnd_sched (default parameters).
// A cycle model predicts handshakes, enables and randomness; issued tags go
// into a scoreboard queue and are popped when a result drains.
module tb_gf16_inv_rnd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        in_valid;
    logic [3:0]  in_tag;
    logic        in_ready;
    logic [11:0] r_out;
    logic [2:0]  stage_en;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic        out_ready;
    logic        flush;
    logic [15:0] starve_cnt;

    always #5 clk = ~clk;

    gf16_inv_rnd_sched #(.STAGES(3), .FIFO_DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .r_out     (r_out),
        .stage_en  (stage_en),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .flush     (flush),
        .starve_cnt(starve_cnt)
    );

    typedef struct {
        logic [3:0] tag;
        int         cyc;
    } sb_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          chk_on = 1'b0;
    bit          lat_on = 1'b0;
    logic [11:0] mf [$];
    sb_t         sb_q [$];
    logic [2:0]  mv = 3'b000;
    logic [15:0] mstarve = 16'h0000;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at posedge+1 with inputs already applied; checks, updates the model, advances one cycle.
    task automatic step();
        bit          adv;
        bit          nonempty;
        bit          iss;
        bit          psh;
        bit          strv;
        bit          drn;
        logic [2:0]  en;
        logic [11:0] er;
        sb_t         e;
        #1;
        nonempty = (mf.size() > 0);
        adv      = !mv[2] || out_ready;
        iss      = rst_n && in_valid && adv && nonempty && !flush;
        psh      = rst_n && rnd_valid && (mf.size() < 4);
        strv     = rst_n && in_valid && adv && !nonempty && !flush;
        drn      = rst_n && mv[2] && out_ready;
        er       = (rst_n && nonempty) ? mf[0] : 12'h000;
        en[0]    = iss;
        en[1]    = rst_n && adv && mv[0] && !flush;
        en[2]    = rst_n && adv && mv[1] && !flush;
        if (chk_on) begin
            chk_eq("in_ready", {31'd0, in_ready}, {31'd0, rst_n && adv && nonempty && !flush});
            chk_eq("rnd_ready", {31'd0, rnd_ready}, {31'd0, rst_n && (mf.size() < 4)});
            chk_eq("r_out", {20'd0, r_out}, {20'd0, er});
            chk_eq("stage_en", {29'd0, stage_en}, {29'd0, en});
            chk_eq("out_valid", {31'd0, out_valid}, {31'd0, rst_n && mv[2]});
            chk_eq("starve_cnt", {16'd0, starve_cnt}, {16'd0, mstarve});
            chk_eq("fifo_count", {29'd0, dut.fifo_count_r}, mf.size());
        end
        if (drn && (sb_q.size() > 0)) begin
            e = sb_q.pop_front();
            chk_eq("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
            if (lat_on) begin
                chk_eq("latency", cyc - e.cyc, 32'd3);
            end
        end
        if (iss) begin
            e.tag = in_tag;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
        if (!rst_n) begin
            mf.delete();
            sb_q.delete();
            mv      = 3'b000;
            mstarve = 16'h0000;
        end else begin
            if (iss) begin
                void'(mf.pop_front());
            end
            if (psh) begin
                mf.push_back(rnd_in);
            end
            if (strv && (mstarve != 16'hFFFF)) begin
                mstarve = mstarve + 16'h0001;
            end
            if (flush) begin
                mv = 3'b000;
                sb_q.delete();
            end else if (adv) begin
                mv = {mv[1:0], iss};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic rn, input logic rv, input logic [11:0] rin,
                         input logic iv, input logic [3:0] itag,
                         input logic ordy, input logic fl);
        rst_n     = rn;
        rnd_valid = rv;
        rnd_in    = rin;
        in_valid  = iv;
        in_tag    = itag;
        out_ready = ordy;
        flush     = fl;
        step();
    endtask

    initial begin
        // Reset: the first cycle only clears unknown state, the second is checked.
        chk_on = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_on = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 1'b1, 4'd0, 1'b1, 1'b0);
        chk_eq("rst_out_tag", {28'd0, out_tag}, 32'd0);

        // Basic issue, randomness order and latency.
        lat_on = 1'b1;
        drive(1'b1, 1'b1, 12'h123, 1'b0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'h456, 1'b0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd2, 1'b1, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);
        lat_on = 1'b0;

        // Starvation, then no-bypass of a freshly pushed word.
        repeat (5) drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd3, 1'b1, 1'b0);
        chk_eq("starve_5", {16'd0, starve_cnt}, 32'd5);
        drive(1'b1, 1'b1, 12'hABC, 1'b1, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd3, 1'b1, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);

        // Backpressure: fill the pipeline, stall, then drain in order.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 12'h201 + 12'(k), 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd5 + 4'(k), 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd8, 1'b0, 1'b0);
        chk_eq("bp_count", {29'd0, dut.fifo_count_r}, 32'd1);
        repeat (3) drive(1'b1, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);

        // Full FIFO, push/pop together and pointer wrap.
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd9, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 12'h301 + 12'(k), 1'b0, 4'd0, 1'b1, 1'b0);
        chk_eq("full_rnd_ready", {31'd0, rnd_ready}, 32'd0);
        chk_eq("full_count", {29'd0, dut.fifo_count_r}, 32'd4);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd10, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'h3A0, 1'b1, 4'd11, 1'b1, 1'b0);
        chk_eq("pushpop_count", {29'd0, dut.fifo_count_r}, 32'd3);
        drive(1'b1, 1'b1, 12'h3B0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd12 + 4'(k), 1'b1, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);

        // Flush with two operations in flight.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 12'h401 + 12'(k), 1'b0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd2, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 4'd3, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_eq("flush_count", {29'd0, dut.fifo_count_r}, 32'd1);

        // Reset with operations in flight and three buffered words.
        drive(1'b1, 1'b1, 12'h501, 1'b0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'h502, 1'b0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'h503, 1'b1, 4'd4, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 12'h504, 1'b1, 4'd5, 1'b1, 1'b0);
        chk_eq("pre_rst_count", {29'd0, dut.fifo_count_r}, 32'd3);
        drive(1'b0, 1'b0, 12'h000, 1'b1, 4'd6, 1'b1, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_eq("post_rst_rnd_ready", {31'd0, rnd_ready}, 32'd1);
        chk_eq("post_rst_count", {29'd0, dut.fifo_count_r}, 32'd0);
        chk_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk_eq("post_rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk_eq("post_rst_stage_en", {29'd0, stage_en}, 32'd0);
        chk_eq("post_rst_r_out", {20'd0, r_out}, 32'd0);
        chk_eq("post_rst_starve", {16'd0, starve_cnt}, 32'd0);
        repeat (3) drive(1'b1, 1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
